// File: rtl/regfile_dump_reader_if.sv
// Register-file read port and (addr, data) output stream used by regfile_dump_reader.
// master = the dump reader, slave = register file plus downstream sink.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping range of register-file addresses through one combinational
// read port and streams each (addr, data) snapshot out over valid/ready.
module regfile_dump_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     first_addr,
    input  logic [ADDR_W-1:0]     last_addr,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    // Address after a, wrapping from the top register back to 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == TOP_ADDR) begin
            next_addr = ZERO_ADDR;
        end else begin
            next_addr = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] cur_r, cur_nxt_s;
    logic [ADDR_W-1:0] last_r, last_nxt_s;
    logic [ADDR_W-1:0] rd_addr_r, rd_addr_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic [ADDR_W-1:0] out_addr_r, out_addr_nxt_s;
    logic [DATA_W-1:0] out_data_r, out_data_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              done_r, done_nxt_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output decode; abort outranks the output handshake.
    always_comb begin
        state_nxt_s     = state_r;
        cur_nxt_s       = cur_r;
        last_nxt_s      = last_r;
        rd_addr_nxt_s   = rd_addr_r;
        out_valid_nxt_s = out_valid_r;
        out_addr_nxt_s  = out_addr_r;
        out_data_nxt_s  = out_data_r;
        done_nxt_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cur_nxt_s     = first_addr;
                    last_nxt_s    = last_addr;
                    rd_addr_nxt_s = first_addr;
                    state_nxt_s   = ST_READ;
                end else begin
                    rd_addr_nxt_s = ZERO_ADDR;
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    rd_addr_nxt_s   = ZERO_ADDR;
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    // Snapshot is taken here, so a same-edge write is not seen.
                    out_data_nxt_s  = bus.rd_data;
                    out_addr_nxt_s  = cur_r;
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    rd_addr_nxt_s   = ZERO_ADDR;
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else if (bus.out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    if (cur_r == last_r) begin
                        rd_addr_nxt_s = ZERO_ADDR;
                        done_nxt_s    = 1'b1;
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        cur_nxt_s     = next_addr(cur_r);
                        rd_addr_nxt_s = next_addr(cur_r);
                        state_nxt_s   = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                rd_addr_nxt_s   = ZERO_ADDR;
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r       <= ZERO_ADDR;
            last_r      <= ZERO_ADDR;
            rd_addr_r   <= ZERO_ADDR;
            out_valid_r <= 1'b0;
            out_addr_r  <= ZERO_ADDR;
            out_data_r  <= ZERO_DATA;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cur_r       <= cur_nxt_s;
            last_r      <= last_nxt_s;
            rd_addr_r   <= rd_addr_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_addr_r  <= out_addr_nxt_s;
            out_data_r  <= out_data_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign bus.rd_addr   = rd_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.out_data  = out_data_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed scenarios plus random
// dumps, each compared against an expected word list built from the range rule.
module tb_regfile_dump_reader;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] first_addr = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              busy;
    logic              done;

    logic              we = 1'b0;
    logic [ADDR_W-1:0] wa = '0;
    logic [DATA_W-1:0] wd = '0;
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] model_rf [NUM_REGS];

    int n_cmp = 0;
    int n_fail = 0;
    int got_addr [$];
    logic [DATA_W-1:0] got_data [$];
    int got_cyc [$];
    int done_cnt;
    bit aborted;

    regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.rd_data = rf[bus.rd_addr];

    always @(posedge clk) begin
        if (we) rf[wa] <= wd;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_rf(input bit pattern);
        for (int i = 0; i < NUM_REGS; i++) begin
            @(negedge clk);
            we = 1'b1;
            wa = i[ADDR_W-1:0];
            wd = pattern ? (32'(i) * 32'h11) : $urandom;
            model_rf[i] = wd;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic run_dump(input string tag, input int f, input int l, input int rdy_pct,
                            input int stall_n, input int abort_idx, input int wr_at,
                            input int wr_a, input logic [DATA_W-1:0] wr_d, input bit with_abort);
        int exp_addr [$];
        logic [DATA_W-1:0] exp_data [$];
        int cnt, n_exp, cyc, stalls;
        bit fin, prev_hold;
        logic [ADDR_W-1:0] prev_a;
        logic [DATA_W-1:0] prev_d;
        cnt = (((l - f) % NUM_REGS) + NUM_REGS) % NUM_REGS + 1;
        for (int k = 0; k < cnt; k++) begin
            exp_addr.push_back((f + k) % NUM_REGS);
            exp_data.push_back(model_rf[(f + k) % NUM_REGS]);
        end
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        done_cnt = 0; aborted = 1'b0;
        @(negedge clk);
        first_addr = f[ADDR_W-1:0]; last_addr = l[ADDR_W-1:0];
        start = 1'b1; abort = with_abort;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        first_addr = ADDR_W'($urandom); last_addr = ADDR_W'($urandom);
        check({tag, "/busy_after_start"}, 64'(busy), 64'd1);
        cyc = 0; fin = 1'b0; stalls = 0; prev_hold = 1'b0;
        while (!fin && cyc < 400) begin
            start = 1'b0; we = 1'b0;
            if (done) begin
                done_cnt++; fin = 1'b1;
                check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
                check({tag, "/valid_at_done"}, 64'(bus.out_valid), 64'd0);
            end else if (bus.out_valid && abort_idx == got_addr.size()) begin
                abort = 1'b1; bus.out_ready = 1'b0;
                @(negedge clk);
                abort = 1'b0; aborted = 1'b1; fin = 1'b1;
                check({tag, "/valid_after_abort"}, 64'(bus.out_valid), 64'd0);
                check({tag, "/busy_after_abort"}, 64'(busy), 64'd0);
                check({tag, "/done_after_abort"}, 64'(done), 64'd0);
            end else begin
                if (prev_hold) begin
                    check({tag, "/stall_valid"}, 64'(bus.out_valid), 64'd1);
                    check({tag, "/stall_addr"}, 64'(bus.out_addr), 64'(prev_a));
                    check({tag, "/stall_data"}, 64'(bus.out_data), 64'(prev_d));
                end
                if (bus.out_valid && stalls < stall_n) begin
                    bus.out_ready = 1'b0; stalls++;
                end else begin
                    bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
                end
                // start while busy must be ignored
                if (cyc == 3) start = 1'b1;
                if (cyc == wr_at) begin
                    we = 1'b1; wa = wr_a[ADDR_W-1:0]; wd = wr_d; model_rf[wr_a] = wr_d;
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_a = bus.out_addr; prev_d = bus.out_data;
                if (bus.out_valid && bus.out_ready) begin
                    got_addr.push_back(int'(bus.out_addr));
                    got_data.push_back(bus.out_data);
                    got_cyc.push_back(cyc);
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; we = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;
        check({tag, "/finished"}, 64'(fin), 64'd1);
        @(negedge clk);
        check({tag, "/done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "/idle_after"}, 64'(busy), 64'd0);
        n_exp = aborted ? abort_idx : cnt;
        check({tag, "/word_count"}, 64'(got_addr.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < got_addr.size(); i++) begin
            check($sformatf("%s/addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
            check($sformatf("%s/data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
        end
        check({tag, "/done_count"}, 64'(done_cnt), aborted ? 64'd0 : 64'd1);
        if (rdy_pct == 100 && stall_n == 0 && got_cyc.size() > 0) begin
            check({tag, "/latency"}, 64'(got_cyc[0]), 64'd1);
            for (int i = 1; i < got_cyc.size(); i++)
                check($sformatf("%s/gap%0d", tag, i), 64'(got_cyc[i] - got_cyc[i-1]), 64'd2);
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        #3;
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/valid", 64'(bus.out_valid), 64'd0);
        check("reset/rd_addr", 64'(bus.rd_addr), 64'd0);
        check("reset/out_addr", 64'(bus.out_addr), 64'd0);
        check("reset/out_data", 64'(bus.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        load_rf(1'b1);
        run_dump("t1_range3_6", 3, 6, 100, 0, -1, -1, 0, 32'd0, 1'b0);
        run_dump("t2_wrap30_1", 30, 1, 100, 0, -1, -1, 0, 32'd0, 1'b0);
        run_dump("t3_single_stall", 7, 7, 100, 5, -1, 3, 7, 32'h0BAD_F00D, 1'b0);
        run_dump("t4_abort", 0, 31, 100, 0, 4, -1, 0, 32'd0, 1'b0);
        run_dump("t4_restart", 10, 12, 70, 0, -1, -1, 0, 32'd0, 1'b0);
        run_dump("t5_snapshot", 5, 5, 100, 0, -1, 0, 5, 32'hDEAD, 1'b0);
        run_dump("t5_reread", 5, 5, 100, 0, -1, -1, 0, 32'd0, 1'b0);
        run_dump("start_and_abort", 20, 22, 100, 0, -1, -1, 0, 32'd0, 1'b1);

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort/busy", 64'(busy), 64'd0);
        check("idle_abort/done", 64'(done), 64'd0);

        // asynchronous reset in the middle of a dump
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("t6/busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6/busy", 64'(busy), 64'd0);
        check("t6/valid", 64'(bus.out_valid), 64'd0);
        check("t6/rd_addr", 64'(bus.rd_addr), 64'd0);
        check("t6/out_addr", 64'(bus.out_addr), 64'd0);
        check("t6/out_data", 64'(bus.out_data), 64'd0);
        check("t6/done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        check("t6/no_done", 64'(done), 64'd0);
        run_dump("t6_after_reset", 28, 2, 100, 0, -1, -1, 0, 32'd0, 1'b0);

        load_rf(1'b0);
        for (int r = 0; r < 6; r++) begin
            int rf_a, rl_a, rp, rs;
            rf_a = $urandom_range(0, NUM_REGS - 1);
            rl_a = $urandom_range(0, NUM_REGS - 1);
            rp = $urandom_range(30, 100);
            rs = $urandom_range(0, 3);
            run_dump($sformatf("rand%0d", r), rf_a, rl_a, rp, rs, -1, -1, 0, 32'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
